// File: rtl/sift_uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter slice.
package sift_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_FETCH
  } state_t;

  localparam logic [7:0]  HEADER_BASE_DEF = 8'hA0;
  localparam int unsigned STALL_MAX_DEF   = 1023;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit; done_o high when idle.
module uart_tx #(
  parameter int unsigned CLOCKS_PER_BAUD = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       tx
);

  localparam int unsigned CW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BAUD - 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          r_tx;

  // r_shift carries the stop bit above the data so the final shift drives the line high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_tx    <= 1'b1;
    end else if (!r_busy) begin
      if (start_i) begin
        r_busy  <= 1'b1;
        r_shift <= {1'b1, data_i};
        r_tx    <= 1'b0;
        r_cnt   <= '0;
        r_bit   <= '0;
      end
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      if (r_bit == 4'd9) begin
        r_busy <= 1'b0;
      end else begin
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
        r_bit   <= r_bit + 4'd1;
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign done_o = ~r_busy;
  assign tx     = r_tx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that packetises byte streams from several requesters onto one UART,
// prefixing each packet with a header byte identifying the owner.
module uart_tx_arbiter
  import sift_uart_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned CLOCKS_PER_BAUD = 50,
  parameter logic [7:0]  HEADER_BASE     = HEADER_BASE_DEF,
  parameter int unsigned STALL_MAX       = STALL_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rst_in_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   stall_err,
  output logic                   tx
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SW = $clog2(STALL_MAX + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_last_grant;
  logic [7:0]         r_byte;
  logic               r_last;
  logic               r_hdr_done;
  logic               r_start;
  logic               r_stall_err;
  logic [SW-1:0]      r_stall_cnt;

  logic               w_done;
  logic               w_sel_any;
  logic [IW-1:0]      w_sel_idx;
  logic [IW-1:0]      w_cand;
  logic               w_g_valid;
  logic               w_g_last;
  logic [7:0]         w_g_data;

  // Search starts one past the previous owner and wraps, so the last winner ranks lowest
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IW'((32'(r_last_grant) + k) % NUM_REQ);
      if (!w_sel_any && req_valid[w_cand]) begin
        w_sel_any = 1'b1;
        w_sel_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_g_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_g_data = w_g_data | req_data[8*i +: 8];
    end
  end

  assign w_g_valid = |(req_valid & r_grant);
  assign w_g_last  = |(req_last & r_grant);

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IW'(NUM_REQ - 1);
      r_byte       <= '0;
      r_last       <= 1'b0;
      r_hdr_done   <= 1'b0;
      r_start      <= 1'b0;
      r_stall_err  <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_any) begin
            r_grant      <= ONE_HOT0 << w_sel_idx;
            r_last_grant <= w_sel_idx;
            r_byte       <= HEADER_BASE | 8'(w_sel_idx);
            r_last       <= 1'b0;
            r_hdr_done   <= 1'b0;
            r_start      <= 1'b1;
            r_state      <= ST_START;
          end
        end
        ST_START: begin
          r_start <= 1'b0;
          r_state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!w_done) r_state <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (w_done) begin
            if (r_hdr_done && r_last) begin
              r_grant <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_hdr_done  <= 1'b1;
              r_stall_cnt <= '0;
              r_state     <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (w_g_valid) begin
            r_byte  <= w_g_data;
            r_last  <= w_g_last;
            r_start <= 1'b1;
            r_state <= ST_START;
          end else if (r_stall_cnt == SW'(STALL_MAX - 1)) begin
            r_stall_cnt <= SW'(STALL_MAX);
            r_stall_err <= 1'b1;
            r_grant     <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ready is decoded from state so it can only ever reach the owner while fetching
  assign req_ready = (r_state == ST_FETCH) ? (r_grant & req_valid) : '0;
  assign grant     = r_grant;
  assign busy      = (r_state != ST_IDLE);
  assign stall_err = r_stall_err;

  uart_tx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_in_n),
    .data_i (r_byte),
    .start_i(r_start),
    .done_o (w_done),
    .tx     (tx)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: decodes tx frames and checks packets, handshakes and reset.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_in_n;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data  = '0;
  logic [1:0]  req_last  = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        stall_err;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(2),
    .CLOCKS_PER_BAUD(CPB),
    .HEADER_BASE(8'hA0),
    .STALL_MAX(1023)
  ) dut (
    .clk(clk), .rst_in_n(rst_in_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
    .stall_err(stall_err), .tx(tx)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] frames[$];
  time        last_rst_time = 0;
  always @(negedge rst_in_n) last_rst_time = $time;

  // Frame decoder: samples mid-bit on falling clock edges; frames overlapped by a reset are dropped
  always begin
    time        t0;
    logic [7:0] b;
    logic       ok;
    @(negedge tx);
    t0 = $time;
    repeat (CPB / 2) @(negedge clk);
    ok = (tx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    ok = ok && (tx === 1'b1);
    if (ok && last_rst_time <= t0) frames.push_back(b);
  end

  // Requester model: pops a byte after a handshake and presents the next queued one
  logic [7:0] qd0[$], qd1[$];
  logic       ql0[$], ql1[$];
  bit         manual = 1'b0;
  logic [1:0] rdy_prev = '0;
  int         ready_cnt0 = 0, ready_cnt1 = 0, viol = 0;

  always begin
    @(negedge clk);
    if (!manual) begin
      if (rdy_prev[0] && qd0.size() > 0) begin void'(qd0.pop_front()); void'(ql0.pop_front()); end
      if (rdy_prev[1] && qd1.size() > 0) begin void'(qd1.pop_front()); void'(ql1.pop_front()); end
      req_valid[0]    = (qd0.size() > 0);
      req_data[7:0]   = (qd0.size() > 0) ? qd0[0] : 8'h00;
      req_last[0]     = (ql0.size() > 0) ? ql0[0] : 1'b0;
      req_valid[1]    = (qd1.size() > 0);
      req_data[15:8]  = (qd1.size() > 0) ? qd1[0] : 8'h00;
      req_last[1]     = (ql1.size() > 0) ? ql1[0] : 1'b0;
    end
    #1;
    rdy_prev = req_ready;
    if (req_ready[0] === 1'b1) ready_cnt0++;
    if (req_ready[1] === 1'b1) ready_cnt1++;
    if ((req_ready & ~grant) != 2'b00) viol++;
  end

  // Start handshake monitor
  int   hs_err = 0, start_cnt = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (dut.u_tx.start_i === 1'b1) begin
      start_cnt++;
      if (dut.u_tx.done_o !== 1'b1) hs_err++;
      if (prev_start) hs_err++;
    end
    prev_start = (dut.u_tx.start_i === 1'b1);
  end

  task automatic clear_tb();
    frames.delete();
    ready_cnt0 = 0;
    ready_cnt1 = 0;
    start_cnt  = 0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (frames.size() >= n) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (busy === 1'b0) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_in_n = 1'b0;
    qd0.push_back(8'h01); ql0.push_back(1'b1);
    qd0.push_back(8'h02); ql0.push_back(1'b1);
    qd1.push_back(8'h11); ql1.push_back(1'b1);
    qd1.push_back(8'h12); ql1.push_back(1'b1);
    repeat (3) @(negedge clk);
    #2;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL reset_stall_err got=%b exp=0", stall_err); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
  endtask

  task automatic test_contention();
    logic [7:0] exp[8];
    logic [7:0] got;
    bit to;
    exp = '{8'hA0, 8'h01, 8'hA1, 8'h11, 8'hA0, 8'h02, 8'hA1, 8'h12};
    clear_tb();
    @(negedge clk);
    rst_in_n = 1'b1;
    wait_frames(8, 3000, to);
    checks++; if (to) begin failures++; $display("FAIL contention_timeout got=%0d frames exp=8", frames.size()); end
    for (int k = 0; k < 8; k++) begin
      got = (k < frames.size()) ? frames[k] : 8'hxx;
      checks++; if (got !== exp[k]) begin failures++; $display("FAIL contention_frame%0d got=%h exp=%h", k, got, exp[k]); end
    end
    wait_idle(20, to);
    checks++; if (to) begin failures++; $display("FAIL contention_idle got=busy exp=idle"); end
    checks++; if (ready_cnt0 !== 2 || ready_cnt1 !== 2) begin failures++; $display("FAIL contention_ready got=%0d/%0d exp=2/2", ready_cnt0, ready_cnt1); end
    checks++; if (start_cnt !== 8) begin failures++; $display("FAIL contention_starts got=%0d exp=8", start_cnt); end
  endtask

  task automatic test_single_packet();
    logic [7:0] exp[3];
    logic [7:0] got;
    bit to;
    exp = '{8'hA1, 8'h12, 8'h34};
    clear_tb();
    qd1.push_back(8'h12); ql1.push_back(1'b0);
    qd1.push_back(8'h34); ql1.push_back(1'b1);
    wait_frames(3, 1000, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout got=%0d frames exp=3", frames.size()); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_in_stop got=%b exp=1", busy); end
    wait_idle(10, to);
    checks++; if (to) begin failures++; $display("FAIL single_busy_fall got=busy exp=idle"); end
    for (int k = 0; k < 3; k++) begin
      got = (k < frames.size()) ? frames[k] : 8'hxx;
      checks++; if (got !== exp[k]) begin failures++; $display("FAIL single_frame%0d got=%h exp=%h", k, got, exp[k]); end
    end
    checks++; if (ready_cnt1 !== 2 || ready_cnt0 !== 0) begin failures++; $display("FAIL single_ready got=%0d/%0d exp=0/2", ready_cnt0, ready_cnt1); end
    checks++; if (start_cnt !== 3) begin failures++; $display("FAIL single_starts got=%0d exp=3", start_cnt); end
  endtask

  task automatic test_single_byte();
    bit to;
    clear_tb();
    qd0.push_back(8'hFF); ql0.push_back(1'b1);
    wait_frames(2, 1000, to);
    wait_idle(20, to);
    repeat (20) @(negedge clk);
    checks++; if (frames.size() !== 2) begin failures++; $display("FAIL byte_count got=%0d exp=2", frames.size()); end
    checks++; if (frames.size() < 2 || frames[0] !== 8'hA0 || frames[1] !== 8'hFF) begin
      failures++; $display("FAIL byte_frames got=%p exp=A0,FF", frames);
    end
    checks++; if (ready_cnt0 !== 1) begin failures++; $display("FAIL byte_ready got=%0d exp=1", ready_cnt0); end
    checks++; if (start_cnt !== 2) begin failures++; $display("FAIL byte_starts got=%0d exp=2", start_cnt); end
  endtask

  task automatic test_stall();
    bit to;
    clear_tb();
    manual = 1'b1;
    req_valid = 2'b01;
    req_data  = 16'h0077;
    req_last  = 2'b00;
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (grant === 2'b01) begin to = 1'b0; break; end
    end
    req_valid = 2'b00;
    checks++; if (to) begin failures++; $display("FAIL stall_grant got=%b exp=01", grant); end
    wait_frames(1, 200, to);
    repeat (1000) @(negedge clk);
    checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL stall_early got=%b exp=0", stall_err); end
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall_err === 1'b1) begin to = 1'b0; break; end
    end
    checks++; if (to) begin failures++; $display("FAIL stall_err got=%b exp=1", stall_err); end
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL stall_abort got=grant %b busy %b exp=grant 00 busy 0", grant, busy); end
    repeat (100) @(negedge clk);
    checks++; if (frames.size() !== 1 || frames[0] !== 8'hA0) begin failures++; $display("FAIL stall_frames got=%p exp=A0", frames); end
    checks++; if (start_cnt !== 1 || ready_cnt0 !== 0) begin failures++; $display("FAIL stall_starts got=%0d/%0d exp=1/0", start_cnt, ready_cnt0); end
    checks++; if (stall_err !== 1'b1) begin failures++; $display("FAIL stall_sticky got=%b exp=1", stall_err); end
    manual = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit to;
    clear_tb();
    qd1.push_back(8'h55); ql1.push_back(1'b1);
    wait_frames(1, 500, to);
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    #2;
    rst_in_n = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin
      failures++; $display("FAIL midrst_async got=grant %b busy %b ready %b exp=00 0 00", grant, busy, req_ready);
    end
    checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL midrst_stall_err got=%b exp=0", stall_err); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", tx); end
    qd0.delete(); ql0.delete(); qd1.delete(); ql1.delete();
    repeat (3) @(negedge clk);
    rst_in_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_after got=tx %b busy %b exp=1 0", tx, busy); end
    checks++; if (frames.size() !== 1) begin failures++; $display("FAIL midrst_frames got=%0d exp=1", frames.size()); end
  endtask

  initial begin
    rst_in_n = 1'b0;
    test_reset();
    test_contention();
    test_single_packet();
    test_single_byte();
    test_stall();
    test_reset_midframe();
    checks++; if (hs_err !== 0) begin failures++; $display("FAIL handshake got=%0d errors exp=0", hs_err); end
    checks++; if (viol !== 0) begin failures++; $display("FAIL ready_to_nongranted got=%0d exp=0", viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
